// File: rtl/hazard_stall_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_unit_pkg
// Purpose  : Shared pipeline definitions for the hazard/stall control slice:
//            register-index width, the hard-wired zero register, and the
//            stall-unit state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_stall_unit_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

endpackage : hazard_stall_unit_pkg
`default_nettype wire

// File: rtl/hazard_stall_unit_match.sv
`default_nettype none
// ============================================================================
// Module   : hazard_match
// Purpose  : Operand-dependency comparator. Flags when a producer destination
//            register is read by the instruction in ID. The zero register is
//            never a dependency because it is hard-wired.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_match
  import hazard_stall_unit_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rd_i,
  input  logic [REG_IDX_W-1:0] rs_i,
  input  logic [REG_IDX_W-1:0] rt_i,
  input  logic                 uses_rt_i,
  output logic                 match_o
);

  // Producer destination against the consumer's source operands
  always_comb begin
    match_o = (rd_i != REG_ZERO) &&
              ((rd_i == rs_i) || (uses_rt_i && (rd_i == rt_i)));
  end

endmodule : hazard_match
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_unit
// Purpose  : Holds the ID consumer when forwarding cannot cover a hazard
//            (load-use, branch-in-ID operands), freezes the back end while
//            data memory is busy, flushes IF/ID on taken branches and keeps
//            stall/flush statistics plus a sticky memory-timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] ifIdRs,
  input  logic [REG_IDX_W-1:0] ifIdRt,
  input  logic                 ifIdUsesRt,
  input  logic                 ifIdIsBranch,
  input  logic                 branchTaken,
  input  logic                 idExMemRead,
  input  logic                 idExRegWrite,
  input  logic [REG_IDX_W-1:0] idExRd,
  input  logic                 exMemMemRead,
  input  logic [REG_IDX_W-1:0] exMemRd,
  input  logic                 dmemReq,
  input  logic                 dmemReady,
  output logic                 pcWrite,
  output logic                 ifIdWrite,
  output logic                 ifIdFlush,
  output logic                 idExBubble,
  output logic                 pipeFreeze,
  output logic                 memError,
  output logic [CNT_W-1:0]     stallCycles,
  output logic [CNT_W-1:0]     flushCount
);

  // Wait counter only needs to reach the timeout value; it saturates above it.
  localparam int               WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = {WAIT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   waitCnt_q, waitCnt_d;
  logic                memError_q, memError_d;
  logic [CNT_W-1:0]    stallCycles_q, stallCycles_d;
  logic [CNT_W-1:0]    flushCount_q, flushCount_d;

  logic idExMatch;
  logic exMemMatch;
  logic loadUse;
  logic brHaz;
  logic memWait;
  logic freeze;
  logic flushEvent;

  hazard_match u_match_idex (
    .rd_i      (idExRd),
    .rs_i      (ifIdRs),
    .rt_i      (ifIdRt),
    .uses_rt_i (ifIdUsesRt),
    .match_o   (idExMatch)
  );

  hazard_match u_match_exmem (
    .rd_i      (exMemRd),
    .rs_i      (ifIdRs),
    .rt_i      (ifIdRt),
    .uses_rt_i (ifIdUsesRt),
    .match_o   (exMemMatch)
  );

  // Hazard terms; in MEM_WAIT the freeze is released by ready alone
  always_comb begin
    loadUse = idExMemRead && idExMatch;
    brHaz   = ifIdIsBranch &&
              ((idExRegWrite && idExMatch) || (exMemMemRead && exMemMatch));
    memWait = dmemReq && !dmemReady;
    freeze  = (state_q == ST_RUN) ? memWait : !dmemReady;
  end

  // Pipeline controls, prioritised: reset > memory freeze > data stall > flush
  always_comb begin
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    ifIdFlush  = 1'b0;
    idExBubble = 1'b0;
    pipeFreeze = 1'b0;
    flushEvent = 1'b0;
    if (reset) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      ifIdFlush  = 1'b1;
      idExBubble = 1'b1;
    end else if (freeze) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      pipeFreeze = 1'b1;
    end else if (loadUse || brHaz) begin
      // branchTaken is ignored here: the comparator saw stale operands
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExBubble = 1'b1;
    end else if (ifIdIsBranch && branchTaken) begin
      ifIdFlush  = 1'b1;
      flushEvent = 1'b1;
    end
  end

  // Next state, wait counter, sticky timeout flag and saturating statistics
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    memError_d = memError_q;
    if (state_q == ST_RUN) begin
      if (memWait) begin
        state_d   = ST_MEM_WAIT;
        waitCnt_d = WAIT_W'(1);
      end
    end else begin
      if (dmemReady) begin
        state_d   = ST_RUN;
        waitCnt_d = '0;
      end else if (waitCnt_q != WAIT_MAX) begin
        waitCnt_d = waitCnt_q + WAIT_W'(1);
      end
    end
    if ((MEM_TIMEOUT != 0) && (state_d == ST_MEM_WAIT) && (waitCnt_d == TIMEOUT_V)) begin
      memError_d = 1'b1;
    end
    stallCycles_d = (!pcWrite && (stallCycles_q != CNT_MAX)) ?
                    stallCycles_q + CNT_W'(1) : stallCycles_q;
    flushCount_d  = (flushEvent && (flushCount_q != CNT_MAX)) ?
                    flushCount_q + CNT_W'(1) : flushCount_q;
  end

  // State and statistics registers; reset also aborts an in-flight wait
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      waitCnt_q     <= '0;
      memError_q    <= 1'b0;
      stallCycles_q <= '0;
      flushCount_q  <= '0;
    end else begin
      state_q       <= state_d;
      waitCnt_q     <= waitCnt_d;
      memError_q    <= memError_d;
      stallCycles_q <= stallCycles_d;
      flushCount_q  <= flushCount_d;
    end
  end

  assign memError    = memError_q;
  assign stallCycles = stallCycles_q;
  assign flushCount  = flushCount_q;

endmodule : hazard_stall_unit
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_unit
// Purpose  : Self-checking bench for hazard_stall_unit: single-cycle control
//            vectors from a table plus multi-cycle sequences for stalls,
//            memory waits, timeout, reset mid-wait and counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 4;

  typedef struct packed {
    logic pcW;
    logic ifW;
    logic flush;
    logic bub;
    logic frz;
  } ctrl_t;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRt;
    logic       isBr;
    logic       taken;
    logic       idExMR;
    logic       idExRW;
    logic [4:0] idExRd;
    logic       exMemMR;
    logic [4:0] exMemRd;
    logic       req;
    logic       rdy;
  } in_t;

  typedef struct {
    string name;
    in_t   in;
    ctrl_t exp;
  } vec_t;

  localparam ctrl_t C_RUN   = 5'b11000;
  localparam ctrl_t C_STALL = 5'b00010;
  localparam ctrl_t C_FLUSH = 5'b11100;
  localparam ctrl_t C_FRZ   = 5'b00001;
  localparam ctrl_t C_RST   = 5'b00110;

  logic                clk = 1'b0;
  logic                reset;
  logic [4:0]          ifIdRs, ifIdRt, idExRd, exMemRd;
  logic                ifIdUsesRt, ifIdIsBranch, branchTaken;
  logic                idExMemRead, idExRegWrite, exMemMemRead;
  logic                dmemReq, dmemReady;
  logic                pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeFreeze;
  logic                memError;
  logic [TB_CNT_W-1:0] stallCycles, flushCount;

  int n_cmp = 0;
  int n_bad = 0;

  ctrl_t exp_q[$];
  string name_q[$];
  vec_t  vecs[$];

  hazard_stall_unit #(
    .MEM_TIMEOUT (TB_TIMEOUT),
    .CNT_W       (TB_CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ifIdRs       (ifIdRs),
    .ifIdRt       (ifIdRt),
    .ifIdUsesRt   (ifIdUsesRt),
    .ifIdIsBranch (ifIdIsBranch),
    .branchTaken  (branchTaken),
    .idExMemRead  (idExMemRead),
    .idExRegWrite (idExRegWrite),
    .idExRd       (idExRd),
    .exMemMemRead (exMemMemRead),
    .exMemRd      (exMemRd),
    .dmemReq      (dmemReq),
    .dmemReady    (dmemReady),
    .pcWrite      (pcWrite),
    .ifIdWrite    (ifIdWrite),
    .ifIdFlush    (ifIdFlush),
    .idExBubble   (idExBubble),
    .pipeFreeze   (pipeFreeze),
    .memError     (memError),
    .stallCycles  (stallCycles),
    .flushCount   (flushCount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (got no finish, need finish)");
    $fatal(1, "watchdog");
  end

  function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                             input logic isBr, input logic taken, input logic idExMR,
                             input logic idExRW, input logic [4:0] idExRdV, input logic exMemMR,
                             input logic [4:0] exMemRdV, input logic req, input logic rdy);
    in_t v;
    v.rs = rs; v.rt = rt; v.usesRt = usesRt; v.isBr = isBr; v.taken = taken;
    v.idExMR = idExMR; v.idExRW = idExRW; v.idExRd = idExRdV;
    v.exMemMR = exMemMR; v.exMemRd = exMemRdV; v.req = req; v.rdy = rdy;
    return v;
  endfunction

  task automatic apply(input in_t v);
    ifIdRs       = v.rs;
    ifIdRt       = v.rt;
    ifIdUsesRt   = v.usesRt;
    ifIdIsBranch = v.isBr;
    branchTaken  = v.taken;
    idExMemRead  = v.idExMR;
    idExRegWrite = v.idExRW;
    idExRd       = v.idExRd;
    exMemMemRead = v.exMemMR;
    exMemRd      = v.exMemRd;
    dmemReq      = v.req;
    dmemReady    = v.rdy;
  endtask

  // Drive one cycle, queue its expected controls, compare mid-cycle, then clock
  task automatic cycle(input in_t v, input ctrl_t e, input string nm);
    ctrl_t act, req_c;
    string n;
    apply(v);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    act   = '{pcWrite, ifIdWrite, ifIdFlush, idExBubble, pipeFreeze};
    req_c = exp_q.pop_front();
    n     = name_q.pop_front();
    n_cmp++;
    if (act !== req_c) begin
      n_bad++;
      $display("FAIL %s: ctrl {pcW,ifW,flush,bub,frz} got %b need %b", n, act, req_c);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d need %0d", nm, act, req);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(mk(0,0,0,0,0,0,0,0,0,0,0,0), C_RST, "reset_ctrl");
    reset = 1'b0;
  endtask

  in_t idle, lu, brL1, brL2;

  initial begin
    idle = mk(8,9,0,0,0,0,0,0,0,0,0,0);
    lu   = mk(8,9,0,0,0,1,1,8,0,0,0,0);

    // ---- reset state
    do_reset();
    chk("reset_stallCycles", int'(stallCycles), 0);
    chk("reset_flushCount", int'(flushCount), 0);
    chk("reset_memError", int'(memError), 0);

    // ---- table of single-cycle control vectors (state stays RUN)
    vecs.push_back('{"idle",             mk(8,9,0,0,0,0,0,0,0,0,0,0), C_RUN});
    vecs.push_back('{"loaduse_rs",       mk(8,9,0,0,0,1,1,8,0,0,0,0), C_STALL});
    vecs.push_back('{"loaduse_rt",       mk(8,9,1,0,0,1,1,9,0,0,0,0), C_STALL});
    vecs.push_back('{"loaduse_rt_unused",mk(8,9,0,0,0,1,1,9,0,0,0,0), C_RUN});
    vecs.push_back('{"loaduse_r0",       mk(0,9,0,0,0,1,1,0,0,0,0,0), C_RUN});
    vecs.push_back('{"alu_nobranch",     mk(8,9,0,0,0,0,1,8,0,0,0,0), C_RUN});
    vecs.push_back('{"br_taken",         mk(8,9,1,1,1,0,0,0,0,0,0,0), C_FLUSH});
    vecs.push_back('{"br_nottaken",      mk(8,9,1,1,0,0,0,0,0,0,0,0), C_RUN});
    vecs.push_back('{"br_alu_haz",       mk(8,9,0,1,1,0,1,8,0,0,0,0), C_STALL});
    vecs.push_back('{"br_exmem_load",    mk(8,9,1,1,1,0,0,0,1,9,0,0), C_STALL});
    vecs.push_back('{"exmem_load_nobr",  mk(8,9,1,0,0,0,0,0,1,8,0,0), C_RUN});
    vecs.push_back('{"br_exmem_alu",     mk(8,9,1,1,1,0,0,0,0,8,0,0), C_FLUSH});
    vecs.push_back('{"br_exmem_r0",      mk(0,9,0,1,1,0,0,0,1,0,0,0), C_FLUSH});
    vecs.push_back('{"dmem_ready_now",   mk(8,9,0,0,0,0,0,0,0,0,1,1), C_RUN});
    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].in, vecs[i].exp, vecs[i].name);
    end

    // ---- load-use: one stall, then rd=0 does not stall
    do_reset();
    cycle(lu, C_STALL, "lu_stall");
    chk("lu_stallCycles", int'(stallCycles), 1);
    cycle(mk(8,9,0,0,0,1,1,0,0,0,0,0), C_RUN, "lu_rd0");
    chk("lu_rd0_stallCycles", int'(stallCycles), 1);

    // ---- branch after ALU op: one stall
    do_reset();
    cycle(mk(8,9,1,1,0,0,1,9,0,0,0,0), C_STALL, "brA_stall");
    cycle(mk(8,9,1,1,0,0,0,0,0,9,0,0), C_RUN,   "brA_go");
    chk("brA_stallCycles", int'(stallCycles), 1);

    // ---- branch after load: two stalls then taken flush
    do_reset();
    brL1 = mk(8,9,1,1,1,1,1,9,0,0,0,0);
    brL2 = mk(8,9,1,1,1,0,0,0,1,9,0,0);
    cycle(brL1, C_STALL, "brL_stall1");
    cycle(brL2, C_STALL, "brL_stall2");
    cycle(mk(8,9,1,1,1,0,0,0,0,9,0,0), C_FLUSH, "brL_flush");
    chk("brL_flushCount", int'(flushCount), 1);
    chk("brL_stallCycles", int'(stallCycles), 2);
    cycle(idle, C_RUN, "brL_after");
    chk("brL_flushCount_once", int'(flushCount), 1);

    // ---- memory wait with concurrent load-use
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(mk(8,9,0,0,0,1,1,8,0,0,1,0), C_FRZ, $sformatf("mw_freeze%0d", k));
    end
    chk("mw_stallCycles_frozen", int'(stallCycles), 3);
    cycle(mk(8,9,0,0,0,1,1,8,0,0,1,1), C_STALL, "mw_release_lu");
    cycle(idle, C_RUN, "mw_back_run");
    chk("mw_stallCycles", int'(stallCycles), 4);
    chk("mw_memError", int'(memError), 0);

    // ---- timeout: memError rises when waitCnt reaches 4, sticky until reset
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      cycle(mk(8,9,0,0,0,0,0,0,0,0,1,0), C_FRZ, $sformatf("to_freeze%0d", k));
      chk($sformatf("to_memError%0d", k), int'(memError), (k >= TB_TIMEOUT) ? 1 : 0);
    end
    cycle(mk(8,9,0,0,0,0,0,0,0,0,1,1), C_RUN, "to_release");
    chk("to_memError_after_ready", int'(memError), 1);
    cycle(idle, C_RUN, "to_idle");
    chk("to_memError_sticky", int'(memError), 1);
    do_reset();
    chk("to_memError_cleared", int'(memError), 0);

    // ---- reset in the second MEM_WAIT cycle
    do_reset();
    cycle(mk(8,9,0,0,0,0,0,0,0,0,1,0), C_FRZ, "rw_freeze1");
    chk("rw_stallCycles_pre", int'(stallCycles), 1);
    reset = 1'b1;
    cycle(mk(8,9,0,0,0,0,0,0,0,0,1,0), C_RST, "rw_reset_ctrl");
    reset = 1'b0;
    chk("rw_stallCycles", int'(stallCycles), 0);
    chk("rw_flushCount", int'(flushCount), 0);
    chk("rw_memError", int'(memError), 0);
    cycle(idle, C_RUN, "rw_run");
    chk("rw_stallCycles_after", int'(stallCycles), 0);

    // ---- saturation with 20 consecutive stalls
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      cycle(lu, C_STALL, $sformatf("sat_stall%0d", k));
      if (k == 14) chk("sat_stallCycles14", int'(stallCycles), 14);
    end
    chk("sat_stallCycles", int'(stallCycles), 15);

    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_hazard_stall_unit
`default_nettype wire

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Companion to the forwarding unit. Forwarding sends results forward to the consumer. This block holds the consumer back when forwarding cannot cover the hazard. It detects load-use and branch-in-ID operand hazards and freezes the whole pipeline while data memory is not ready. It flushes IF/ID on taken branches and keeps stall/flush statistics. It sits beside the IF/ID and ID/EX pipeline registers and drives their write enables and the bubble mux.

Parameters:
MEM_TIMEOUT, 16, memory-wait cycles before memError sets; 0 disables the timeout.
CNT_W, 32, width of the statistics counters.

Ports:
clk  input  1  pipeline clock
reset  input  1  synchronous, active-high reset
ifIdRs  input  5  rs of the instruction in ID
ifIdRt  input  5  rt of the instruction in ID
ifIdUsesRt  input  1  ID instruction reads rt
ifIdIsBranch  input  1  ID instruction is beq/bne, resolved in ID
branchTaken  input  1  ID branch comparator result
idExMemRead  input  1  EX instruction is a load
idExRegWrite  input  1  EX instruction writes a register
idExRd  input  5  EX destination (already muxed rt/rd)
exMemMemRead  input  1  MEM instruction is a load
exMemRd  input  5  MEM destination
dmemReq  input  1  MEM stage is accessing data memory
dmemReady  input  1  data memory completes this cycle
pcWrite  output  1  PC enable
ifIdWrite  output  1  IF/ID enable
ifIdFlush  output  1  zero IF/ID at next edge
idExBubble  output  1  load zero controls into ID/EX
pipeFreeze  output  1  hold ID/EX, EX/MEM, MEM/WB
memError  output  1  sticky memory timeout flag
stallCycles  output  CNT_W  cycles with pcWrite=0
flushCount  output  CNT_W  taken-branch flushes

Behaviour:
- Controls are combinational from the inputs and the registered state. Counters and memError are registered.
- While reset=1 the controls are pcWrite=0, ifIdWrite=0, ifIdFlush=1, idExBubble=1, pipeFreeze=0.
- At the reset edge: state=RUN, waitCnt=0, memError=0, stallCycles=0, flushCount=0.
- A reset during MEM_WAIT aborts the wait immediately.
- Match(r) means: r!=0 and (r==ifIdRs or (ifIdUsesRt and r==ifIdRt)). Register 0 never causes a stall.
- loadUse = idExMemRead and Match(idExRd).
- brHaz = ifIdIsBranch and ((idExRegWrite and Match(idExRd)) or (exMemMemRead and Match(exMemRd))).
  - A branch after an ALU op stalls 1 cycle.
  - A branch after a load stalls 2 cycles: first via idEx, then via exMem.
- memWait = dmemReq and not dmemReady.
- State RUN:
  - If memWait: pipeFreeze=1, pcWrite=0, ifIdWrite=0, idExBubble=0, ifIdFlush=0; next state MEM_WAIT, waitCnt=1.
  - Else if loadUse or brHaz: pcWrite=0, ifIdWrite=0, idExBubble=1. branchTaken is ignored because the operands are stale.
  - Else if ifIdIsBranch and branchTaken: ifIdFlush=1 for one cycle; flushCount increments.
  - Else all enables are 1 and all kill signals are 0.
- State MEM_WAIT:
  - While dmemReady=0: full freeze as above; waitCnt increments and saturates.
  - When MEM_TIMEOUT!=0 and waitCnt reaches MEM_TIMEOUT, memError sets and stays set until reset. The block continues waiting.
  - When dmemReady=1 the freeze drops in that same cycle, hazard logic evaluates as in RUN, next state is RUN and waitCnt=0.
- Priority: memory freeze > data-hazard stall > branch flush. A frozen cycle never flushes or bubbles.
- dmemReq must stay high until ready; the block does not check this.
- stallCycles increments in every cycle with pcWrite=0 while reset=0. Both counters saturate at all-ones.

Decomposition:
- Shared pipeline package holds:
  - the state encoding (RUN=1'b0, MEM_WAIT=1'b1);
  - the register-zero constant;
  - the 5-bit register-index width.
- One natural sub-module: hazard_match, the combinational Match() comparator, instantiated for the idEx and exMem destinations.
- The counters stay inline.

Test Plan:
- Load-use: idExMemRead=1, idExRd=8, ifIdRs=8 -> one cycle of pcWrite=0, ifIdWrite=0, idExBubble=1, stallCycles=1. The same stimulus with idExRd=0 -> no stall.
- Branch hazards: ifIdIsBranch=1, ifIdRt=9, ifIdUsesRt=1.
  - An ALU op with idExRd=9 -> 1 stall cycle.
  - A load to 9 -> 2 stall cycles (idEx then exMem), then branchTaken=1 -> ifIdFlush=1 once, flushCount=1.
- Memory wait: dmemReq=1, dmemReady=0 for 3 cycles then 1 -> pipeFreeze=1 for exactly 3 cycles, drops in the ready cycle, state back to RUN. A concurrent loadUse is asserted only in the release cycle.
- Timeout: MEM_TIMEOUT=4, ready held low for 6 cycles -> memError rises when waitCnt reaches 4 and stays high after ready; it clears only by reset.
- Reset mid-wait: reset asserted in the 2nd MEM_WAIT cycle -> the next cycle is RUN with counters 0, memError=0, and ifIdFlush=1 and idExBubble=1 while reset is high.
- Counter saturation: CNT_W=4 with 20 consecutive stall cycles -> stallCycles holds at 15.
